// File: rtl/wb_regfile_scoreboard.sv
// rtl/wb_regfile_scoreboard.sv - write-back register file with pending-write scoreboard
//
// Purpose: MEM/WB write-back into a 32-entry GPR file with two bypassed ID read
// ports, plus per-register in-flight write counters that stall ID on RAW
// hazards and on counter overflow.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   ReadData, ALU_Result              write-back data candidates
//   Write_Destination, RegWrite,
//   MemtoReg                          write-back control (RegWrite = retire)
//   Read_Reg1/2 -> Read_Data1/2       ID read ports, combinational
//   Issue_Valid, Issue_Use1/2,
//   Issue_Write, Issue_Dest           ID issue attempt
//   Issue_Stall                       issue not accepted this cycle
//   Sb_Error                          sticky: retire with no pending write
module wb_regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] ALU_Result,
  input  logic [ADDR_W-1:0] Write_Destination,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [ADDR_W-1:0] Read_Reg1,
  input  logic [ADDR_W-1:0] Read_Reg2,
  output logic [DATA_W-1:0] Read_Data1,
  output logic [DATA_W-1:0] Read_Data2,
  input  logic              Issue_Valid,
  input  logic              Issue_Use1,
  input  logic              Issue_Use2,
  input  logic              Issue_Write,
  input  logic [ADDR_W-1:0] Issue_Dest,
  output logic              Issue_Stall,
  output logic              Sb_Error
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [ADDR_W-1:0] R0      = '0;

  logic [DATA_W-1:0] rf_q  [NREG];
  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];
  logic              sb_err_q, sb_err_d;

  logic [DATA_W-1:0] wb_data;
  logic              wb_en;
  logic [NREG-1:0]   pend;
  logic              dest_full;
  logic              issue_acc;

  assign wb_data = MemtoReg ? ReadData : ALU_Result;
  assign wb_en   = RegWrite && (Write_Destination != R0);

  // Write-through bypass: a same-cycle retire is visible to ID immediately.
  always_comb begin
    Read_Data1 = rf_q[Read_Reg1];
    if (Read_Reg1 == R0) begin
      Read_Data1 = '0;
    end else if (wb_en && (Write_Destination == Read_Reg1)) begin
      Read_Data1 = wb_data;
    end
  end

  always_comb begin
    Read_Data2 = rf_q[Read_Reg2];
    if (Read_Reg2 == R0) begin
      Read_Data2 = '0;
    end else if (wb_en && (Write_Destination == Read_Reg2)) begin
      Read_Data2 = wb_data;
    end
  end

  // A register whose last in-flight write is retiring this cycle is no longer
  // pending, because the bypass already delivers its value.
  always_comb begin
    pend = '0;
    for (int r = 1; r < NREG; r++) begin
      pend[r] = (cnt_q[r] != CNT_ZERO) &&
                !((cnt_q[r] == CNT_ONE) && wb_en && (Write_Destination == ADDR_W'(r)));
    end
  end

  // Overflow check deliberately ignores a same-cycle retire to keep the path short.
  assign dest_full   = Issue_Write && (Issue_Dest != R0) && (cnt_q[Issue_Dest] == CNT_MAX);
  assign Issue_Stall = Issue_Valid && ((Issue_Use1 && pend[Read_Reg1]) ||
                                       (Issue_Use2 && pend[Read_Reg2]) ||
                                       dest_full);
  assign issue_acc   = Issue_Valid && !Issue_Stall && Issue_Write && (Issue_Dest != R0);

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      logic inc, dec;
      inc      = issue_acc && (Issue_Dest == ADDR_W'(r));
      dec      = wb_en && (Write_Destination == ADDR_W'(r));
      cnt_d[r] = cnt_q[r];
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec && !inc && (cnt_q[r] != CNT_ZERO)) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  // Retiring a register with nothing in flight is an underflow; a same-cycle
  // issue to that register balances it instead.
  assign sb_err_d = sb_err_q ||
                    (wb_en && (cnt_q[Write_Destination] == CNT_ZERO) &&
                     !(issue_acc && (Issue_Dest == Write_Destination)));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        rf_q[r]  <= '0;
        cnt_q[r] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      if (wb_en) begin
        rf_q[Write_Destination] <= wb_data;
      end
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      sb_err_q <= sb_err_d;
    end
  end

  assign Sb_Error = sb_err_q;

endmodule
